// File: rtl/bcd_pkg.sv
// Shared types and constants for the 7-bit binary to two-digit BCD converter.
// Saturation constants are applied only when BCD_SATURATE_EN is defined.
package bcd_pkg;

  localparam int         IN_W_DEF   = 7;
  localparam int         ITER_CNT_W = 3;
  localparam logic [3:0] SAT_TENS   = 4'd9;
  localparam logic [3:0] SAT_ONES   = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bcd_digit_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3) driving a two-digit
// display. Define BCD_SATURATE_EN to show 9,9 for inputs above 99.
module bcd_digit_conv
  import bcd_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] din,
  output logic            busy,
  output logic            done,
  output logic [3:0]      tens,
  output logic [3:0]      ones,
  output logic            ovf
);

`ifdef BCD_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(IN_W - 1);

  state_t                  state_reg, state_next;
  logic [ITER_CNT_W-1:0]   cnt_reg;
  logic [9:0]              bcd_reg;   // {hundreds[1:0], tens[3:0], ones[3:0]}
  logic [IN_W-1:0]         bin_reg;
  logic [3:0]              tens_reg, ones_reg;
  logic                    ovf_reg, done_reg;
  logic [7:0]              adj_bcd;
  logic [IN_W+9:0]         shift_next;
  logic                    hund_nz;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      bcd_add3 u_add3 (
        .nib (bcd_reg[gi*4 +: 4]),
        .adj (adj_bcd[gi*4 +: 4])
      );
    end
  endgenerate

  // Hundreds never exceeds 1 for a 7-bit input, so it needs no corrector.
  assign shift_next = {bcd_reg[8], adj_bcd, bin_reg, 1'b0};
  assign hund_nz    = |bcd_reg[9:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST_ITER) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state_reg)
      SHIFT, DONE: busy = 1'b1;
      default:     busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      bcd_reg  <= '0;
      bin_reg  <= '0;
      tens_reg <= '0;
      ones_reg <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bcd_reg <= '0;
            bin_reg <= din;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          bcd_reg <= shift_next[IN_W+9:IN_W];
          bin_reg <= shift_next[IN_W-1:0];
          cnt_reg <= cnt_reg + 1'b1;
        end
        DONE: begin
          // Display registers change only here, so no partial result is shown.
          tens_reg <= (SAT_EN && hund_nz) ? SAT_TENS : bcd_reg[7:4];
          ones_reg <= (SAT_EN && hund_nz) ? SAT_ONES : bcd_reg[3:0];
          ovf_reg  <= hund_nz;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = done_reg;
  assign tens = tens_reg;
  assign ones = ones_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bcd_digit_conv.sv
// Self-checking bench for bcd_digit_conv: cycle model compared every negedge
// plus directed conversions with literal expectations.
module tb_bcd_digit_conv;

`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] din   = '0;
  logic       busy, done, ovf;
  logic [3:0] tens, ones;

  int checks   = 0;
  int failures = 0;

  bcd_digit_conv #(.IN_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .tens  (tens),
    .ones  (ones),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic int f_tens(int v);
    if (SAT && v > 99) return 9;
    return (v % 100) / 10;
  endfunction

  function automatic int f_ones(int v);
    if (SAT && v > 99) return 9;
    return v % 10;
  endfunction

  // Model: a conversion occupies 8 cycles after acceptance, result lands on the 8th.
  int m_cnt  = 0;
  int m_din  = 0;
  int m_tens = 0;
  int m_ones = 0;
  int m_ovf  = 0;
  int m_done = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_tens <= 0; m_ones <= 0; m_ovf <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (m_cnt == 0) begin
        if (start) begin
          m_din <= int'(din);
          m_cnt <= 8;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_tens <= f_tens(m_din);
          m_ones <= f_ones(m_din);
          m_ovf  <= (m_din > 99) ? 1 : 0;
          m_done <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (busy !== (m_cnt != 0) || done !== (m_done != 0) || int'(tens) != m_tens ||
        int'(ones) != m_ones || int'(ovf) != m_ovf || $isunknown({busy, done, tens, ones, ovf})) begin
      failures++;
      $display("FAIL model_cycle t=%0t actual busy=%b done=%b tens=%0d ones=%0d ovf=%b required busy=%0d done=%0d tens=%0d ones=%0d ovf=%0d",
               $time, busy, done, tens, ones, ovf, (m_cnt != 0), m_done, m_tens, m_ones, m_ovf);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Returns the posedge index (1-based) at which done was seen, 0 on timeout.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_conv(input int v, input int et, input int eo, input int eovf);
    int n;
    @(posedge clk); #2 start = 1'b1; din = 7'(v);
    @(posedge clk); #2 start = 1'b0; din = 7'(v ^ 7'h55);
    wait_done(20, n);
    check("latency", n, 8);
    check("tens", int'(tens), et);
    check("ones", int'(ones), eo);
    check("ovf", int'(ovf), eovf);
    $display("conv din=%0d tens=%0d ones=%0d ovf=%0d latency=%0d", v, tens, ones, ovf, n);
  endtask

  initial begin
    int n;
    start = 1'b1;
    din   = 7'd0;
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_digits", int'({tens, ones, 3'b0, ovf}), 0);
    #10 reset = 1'b0;                      // t=22, next posedge at 25 accepts
    @(posedge clk); #2 start = 1'b0;
    #1 check("busy_after_accept", int'(busy), 1);
    wait_done(20, n);
    check("zero_latency", n, 8);
    check("zero_digits", int'({tens, ones, 3'b0, ovf}), 0);
    $display("conv din=0 tens=%0d ones=%0d ovf=%0d latency=%0d", tens, ones, ovf, n);

    do_conv(42, 4, 2, 0);
    do_conv(99, 9, 9, 0);
    do_conv(127, SAT ? 9 : 2, SAT ? 9 : 7, 1);

    // start held high; din changes during busy
    @(posedge clk); #2 start = 1'b1; din = 7'd57;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 din = 7'd13;
    wait_done(20, n);
    check("held_first_latency", n, 5);
    check("held_first_tens", int'(tens), 5);
    check("held_first_ones", int'(ones), 7);
    $display("conv din=57 tens=%0d ones=%0d ovf=%0d", tens, ones, ovf);
    wait_done(20, n);
    start = 1'b0;
    check("held_second_latency", n, 9);
    check("held_second_tens", int'(tens), 1);
    check("held_second_ones", int'(ones), 3);
    $display("conv din=13 tens=%0d ones=%0d ovf=%0d", tens, ones, ovf);

    do_conv(127, SAT ? 9 : 2, SAT ? 9 : 7, 1);

    // reset mid-conversion of 88
    @(posedge clk); #2 start = 1'b1; din = 7'd88;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #3;
    check("abort_busy", int'(busy), 0);
    check("abort_digits", int'({tens, ones, 3'b0, ovf}), 0);
    #7 reset = 1'b0;
    wait_done(12, n);
    check("abort_no_done", n, 0);
    check("abort_digits_after", int'({tens, ones, 3'b0, ovf}), 0);
    $display("conv din=88 aborted tens=%0d ones=%0d ovf=%0d", tens, ones, ovf);

    do_conv(88, 8, 8, 0);
    do_conv(100, SAT ? 9 : 0, SAT ? 9 : 0, 1);
    do_conv(9, 0, 9, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
